// File: rtl/sobel_stream_sink_if.sv
// Stream, host-readout and status signals of the Sobel output sink, bundled for port use.
// master = IP/host side driving the sink, slave = the sink itself.
interface sobel_stream_sink_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 20
);
    logic              Valid_in;
    logic [DATA_W-1:0] Data_in;
    logic              Last_in;
    logic              Ready_out;
    logic              Stall_in;
    logic              Rd_en;
    logic [DATA_W-1:0] Rd_data;
    logic              Rd_valid;
    logic              Frame_done;
    logic [15:0]       Frame_cnt;
    logic [CNT_W-1:0]  Pixel_cnt;
    logic              Err_early_last;
    logic              Err_missing_last;
    logic              Clr_err;

    modport master (
        output Valid_in, Data_in, Last_in, Stall_in, Rd_en, Clr_err,
        input  Ready_out, Rd_data, Rd_valid, Frame_done, Frame_cnt, Pixel_cnt,
               Err_early_last, Err_missing_last
    );

    modport slave (
        input  Valid_in, Data_in, Last_in, Stall_in, Rd_en, Clr_err,
        output Ready_out, Rd_data, Rd_valid, Frame_done, Frame_cnt, Pixel_cnt,
               Err_early_last, Err_missing_last
    );
endinterface

// File: rtl/sobel_stream_sink.sv
// Sobel output stream sink: show-ahead FIFO for host readout with backpressure,
// frame-length checking against Last_in and a frame counter.
module sobel_stream_sink #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMG_W      = 512,
    parameter int unsigned IMG_H      = 512,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 20
) (
    input  logic              Clk,
    input  logic              rst,
    sobel_stream_sink_if.slave s
);
    localparam int unsigned N  = IMG_W * IMG_H;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N - 1);
    localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, RECV} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_next;
    logic              full_q;
    logic              ready, accept, pop;

    state_t            state, state_next;
    logic [CNT_W-1:0]  pix_cnt, pix_next;
    logic              last_beat, close, early, missing;
    logic              frame_done_q;
    logic [15:0]       frame_cnt_q;
    logic              err_early_q, err_missing_q;

    assign ready  = !rst && !full_q && !s.Stall_in;
    assign accept = s.Valid_in && ready;
    assign pop    = s.Rd_en && (count != '0);

    always_comb begin
        count_next = count;
        if (accept && !pop)
            count_next = count + 1'b1;
        else if (!accept && pop)
            count_next = count - 1'b1;
    end

    // Storage carries no reset; visibility is governed by count alone.
    always_ff @(posedge Clk) begin
        if (accept)
            mem[wr_ptr] <= s.Data_in;
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count  <= count_next;
            full_q <= (count_next == FULL_CNT);
        end
    end

    assign last_beat = (pix_cnt == LAST_IDX);
    assign close     = accept && (s.Last_in || last_beat);
    assign early     = accept && s.Last_in && !last_beat;
    assign missing   = accept && last_beat && !s.Last_in;

    always_comb begin
        state_next = state;
        pix_next   = pix_cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (close) begin
                        state_next = IDLE;
                        pix_next   = '0;
                    end else begin
                        state_next = RECV;
                        pix_next   = pix_cnt + 1'b1;
                    end
                end
            end
            RECV: begin
                if (accept) begin
                    if (close) begin
                        state_next = IDLE;
                        pix_next   = '0;
                    end else begin
                        pix_next   = pix_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                pix_next   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state         <= IDLE;
            pix_cnt       <= '0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
        end else begin
            state        <= state_next;
            pix_cnt      <= pix_next;
            frame_done_q <= close;
            if (close)
                frame_cnt_q <= frame_cnt_q + 16'd1;
            // A new error outranks a simultaneous clear.
            err_early_q   <= early   || (err_early_q   && !s.Clr_err);
            err_missing_q <= missing || (err_missing_q && !s.Clr_err);
        end
    end

    assign s.Ready_out        = ready;
    assign s.Rd_valid         = (count != '0);
    assign s.Rd_data          = (count != '0) ? mem[rd_ptr] : '0;
    assign s.Frame_done       = frame_done_q;
    assign s.Frame_cnt        = frame_cnt_q;
    assign s.Pixel_cnt        = pix_cnt;
    assign s.Err_early_last   = err_early_q;
    assign s.Err_missing_last = err_missing_q;
endmodule
